alu_reg_sequencer: RTL and testbench

//  Command-driven controller for the 4-bit accumulator datapath: alu (oc,a,b->f) + register (cl/ld/inc/dec/sr/sl/ir/il).

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_decode.sv | 62 ++++++
 rtl/alu_reg_sequencer.sv | 116 +++++++++++
 tb/tb_alu_reg_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_reg_sequencer controller and its strobe decoder.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int ALU_OP_BIT = 3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  // Bit order matches the {cl, ld, inc, dec, sr, sl, ir, il} strobe vector.
  typedef struct packed {
    logic cl;
    logic ld;
    logic inc;
    logic dec;
    logic sr;
    logic sl;
    logic ir;
    logic il;
  } reg_ctrl_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return !op[ALU_OP_BIT] && (op[2:0] >= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of sequencer state + latched command into register strobes,
// register load value and ALU opcode.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OC_W  = 3
) (
  input  logic [1:0]       state,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             reg_lsb,
  output logic [7:0]       strobes,
  output logic [WIDTH-1:0] reg_in,
  output logic [OC_W-1:0]  alu_oc
);

  reg_ctrl_t ctrl;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl   = '0;
    reg_in = '0;
    alu_oc = '0;
    case (state_e'(state))
      EXEC: begin
        if (op[ALU_OP_BIT]) begin
          alu_oc  = OC_W'(op[2:0]);
          ctrl.ld = 1'b1;
          reg_in  = alu_f;
        end else begin
          case (op[2:0])
            OP_CLR:  ctrl.cl = 1'b1;
            OP_LOAD: begin
              ctrl.ld = 1'b1;
              reg_in  = data;
            end
            OP_INC:  ctrl.inc = 1'b1;
            OP_DEC:  ctrl.dec = 1'b1;
            default: ;
          endcase
        end
      end
      SHIFT: begin
        case (op[2:0])
          OP_SHR: ctrl.sr = 1'b1;
          OP_SHL: ctrl.sl = 1'b1;
          OP_ROR: begin
            ctrl.sr = 1'b1;
            ctrl.ir = reg_lsb;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign strobes = ctrl;

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command sequencer driving an ALU + shift register pair; one command per handshake,
// result returned on a valid/ready response port. Optional SEQ_ZERO_FLAG_EN adds resp_zero.
module alu_reg_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int OC_W    = 3,
  parameter int SHAMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
`ifdef SEQ_ZERO_FLAG_EN
  output logic             resp_zero,
`endif
  output logic [OC_W-1:0]  alu_oc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out
);

  localparam int CNT_W = SHAMT_W + 1;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         strobes;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (is_shift_op(cmd_op)) begin
            state_d = SHIFT;
            count_d = CNT_W'(cmd_data[SHAMT_W-1:0]) + CNT_W'(1);
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC:  state_d = RESP;
      SHIFT: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Async reset returns to IDLE at once, which drops all decoded strobes without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  alu_seq_decode #(
    .WIDTH (WIDTH),
    .OC_W  (OC_W)
  ) u_decode (
    .state   (state_q),
    .op      (op_q),
    .data    (data_q),
    .alu_f   (alu_f),
    .reg_lsb (reg_out[0]),
    .strobes (strobes),
    .reg_in  (reg_in),
    .alu_oc  (alu_oc)
  );

  assign {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il} = strobes;

  assign cmd_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_valid ? reg_out : '0;
  assign alu_a      = reg_out;
  assign alu_b      = data_q;

`ifdef SEQ_ZERO_FLAG_EN
  assign resp_zero  = resp_valid && (reg_out == '0);
`endif

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Bench for alu_reg_sequencer: closes the loop with a behavioural ALU and register and
// checks each command against a transaction-level model.
module tb_alu_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op, cmd_data;
  logic       resp_valid, resp_ready;
  logic [3:0] resp_data;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b, alu_f;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_in, reg_out;
`ifdef SEQ_ZERO_FLAG_EN
  logic       resp_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] model_reg;

  always #5 clk = ~clk;

  alu_reg_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef SEQ_ZERO_FLAG_EN
    .resp_zero  (resp_zero),
`endif
    .alu_oc     (alu_oc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .reg_cl     (reg_cl),
    .reg_ld     (reg_ld),
    .reg_inc    (reg_inc),
    .reg_dec    (reg_dec),
    .reg_sr     (reg_sr),
    .reg_ir     (reg_ir),
    .reg_sl     (reg_sl),
    .reg_il     (reg_il),
    .reg_in     (reg_in),
    .reg_out    (reg_out)
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return b;
      default: return a + 4'd1;
    endcase
  endfunction

  assign alu_f = alu_fn(alu_oc, alu_a, alu_b);

  // Behavioural register: the ports the sequencer drives, cleared with the bench reset.
  logic [3:0] reg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reg_q <= '0;
    else if (reg_cl)  reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 4'd1;
    else if (reg_dec) reg_q <= reg_q - 4'd1;
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[3:1]};
    else if (reg_sl)  reg_q <= {reg_q[2:0], reg_il};
  end
  assign reg_out = reg_q;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int shift_count(input logic [3:0] op, input logic [3:0] d);
    if (!op[3] && op[2:0] >= 3'd5) return int'(d[1:0]) + 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] op, input logic [3:0] d, input logic [3:0] r);
    int n;
    logic [7:0] rr;
    n  = int'(d[1:0]) + 1;
    rr = {r, r} >> n;
    if (op[3]) return alu_fn(op[2:0], r, d);
    case (op[2:0])
      3'd0: return r;
      3'd1: return 4'd0;
      3'd2: return d;
      3'd3: return r + 4'd1;
      3'd4: return r - 4'd1;
      3'd5: return r >> n;
      3'd6: return r << n;
      default: return rr[3:0];
    endcase
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}, 8'h00);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [3:0] d, input int hold);
    logic [3:0] exp;
    int n, lat, n_cl, n_ld, n_inc, n_dec, n_sr, n_sl;
    logic got;
    exp = model_next(op, d, model_reg);
    n   = shift_count(op, d);
    n_cl = 0; n_ld = 0; n_inc = 0; n_dec = 0; n_sr = 0; n_sl = 0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_data   = d;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom);
    cmd_data  = 4'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        check("onehot", ($countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}) <= 1), 1);
        check("il_zero", reg_il, 0);
        check("cmd_ready_busy", cmd_ready, 0);
        if (reg_sr) check("ir_value", reg_ir, (op[2:0] == 3'd7) ? reg_out[0] : 1'b0);
        if (reg_ld && op[3]) begin
          check("alu_oc", alu_oc, op[2:0]);
          check("alu_a", alu_a, model_reg);
          check("alu_b", alu_b, d);
          check("reg_in_alu", reg_in, alu_fn(op[2:0], model_reg, d));
        end
        if (reg_ld && !op[3]) check("reg_in_load", reg_in, d);
        n_cl += int'(reg_cl); n_ld += int'(reg_ld); n_inc += int'(reg_inc);
        n_dec += int'(reg_dec); n_sr += int'(reg_sr); n_sl += int'(reg_sl);
      end
    end
    check("resp_seen", got, 1);
    check("latency", lat, (n > 0) ? n + 1 : 2);
    check("resp_data", resp_data, exp);
    check("cmd_ready_resp", cmd_ready, 0);
    check_quiet("resp");
    check("n_cl", n_cl, (!op[3] && op[2:0] == 3'd1) ? 1 : 0);
    check("n_ld", n_ld, (op[3] || op[2:0] == 3'd2) ? 1 : 0);
    check("n_inc", n_inc, (!op[3] && op[2:0] == 3'd3) ? 1 : 0);
    check("n_dec", n_dec, (!op[3] && op[2:0] == 3'd4) ? 1 : 0);
    check("n_sr", n_sr, (!op[3] && (op[2:0] == 3'd5 || op[2:0] == 3'd7)) ? n : 0);
    check("n_sl", n_sl, (!op[3] && op[2:0] == 3'd6) ? n : 0);
`ifdef SEQ_ZERO_FLAG_EN
    check("resp_zero", resp_zero, (exp == 4'd0));
`endif
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, exp);
      check("hold_cmd_ready", cmd_ready, 0);
      check_quiet("hold");
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("release_idle", cmd_ready, 1);
    check("release_valid", resp_valid, 0);
`ifdef SEQ_ZERO_FLAG_EN
    check("release_zero", resp_zero, 0);
`endif
    model_reg = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_data   = '0;
    resp_ready = 1'b0;
    model_reg  = '0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_alu_oc", alu_oc, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_reg_in", reg_in, 0);
    check_quiet("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(4'd2, 4'b1010, 0);   // LOAD
    run_cmd(4'd2, 4'b1111, 0);
    run_cmd(4'd3, 4'd0, 0);      // INC wraps to 0
    run_cmd(4'd4, 4'd0, 0);      // DEC wraps to F
    run_cmd(4'd2, 4'b1001, 0);
    run_cmd(4'd5, 4'b0010, 0);   // SHR by 3 -> 0001
    run_cmd(4'd2, 4'b1001, 0);
    run_cmd(4'd7, 4'b0010, 0);   // ROR by 3 -> 0011
    run_cmd(4'd2, 4'b0101, 0);
    run_cmd(4'b1000, 4'b0011, 5); // ALU add, response held 5 cycles
    run_cmd(4'd1, 4'd7, 1);       // CLR
    run_cmd(4'd0, 4'd3, 0);       // NOP

    // Reset in the middle of a 4-cycle shift.
    run_cmd(4'd2, 4'b1110, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd5;
    cmd_data  = 4'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_shift_sr", reg_sr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    model_reg = '0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_reg", reg_out, 0);

    for (int t = 0; t < 60; t++) begin
      run_cmd(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
